// File: rtl/pc_seq.sv
// PC sequencer: BOOT -> FETCH -> EXEC -> UPDATE control loop with trap/mret/irq redirection.
// Optional interrupt support is enabled by defining PC_SEQ_IRQ_EN.
module pc_seq #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0010
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_o,
  output logic        set_pc_o,
  output logic        fetch_req_o,
  input  logic        fetch_ack_i,
  output logic        exec_start_o,
  input  logic        exec_done_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        trap_i,
  input  logic        mret_i,
  input  logic        irq_i,
  output logic [31:0] mepc_o,
  output logic        in_trap_o
);

  typedef enum logic [1:0] {BOOT, FETCH, EXEC, UPDATE} state_t;

  state_t      state;
  logic [31:0] pc_plus4;
  logic        irq_take;
  logic        trap_take;

  assign pc_plus4  = pc_i + 32'd4;
  // mret outside a handler is illegal and is routed as a trap
  assign trap_take = trap_i | (mret_i & ~in_trap_o);

`ifdef PC_SEQ_IRQ_EN
  assign irq_take = irq_i & ~in_trap_o;
`else
  logic unused_irq;
  assign unused_irq = irq_i;
  assign irq_take   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= BOOT;
      set_pc_o     <= 1'b0;
      fetch_req_o  <= 1'b0;
      exec_start_o <= 1'b0;
      pc_o         <= RESET_VEC;
      mepc_o       <= 32'h0;
      in_trap_o    <= 1'b0;
    end else begin
      case (state)
        // BOOT is entered with set_pc_o low; the strobe cycle follows, then FETCH
        BOOT: begin
          if (!set_pc_o) begin
            set_pc_o <= 1'b1;
            pc_o     <= RESET_VEC;
          end else begin
            set_pc_o    <= 1'b0;
            fetch_req_o <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (fetch_ack_i) begin
            fetch_req_o  <= 1'b0;
            exec_start_o <= 1'b1;
            state        <= EXEC;
          end
        end
        EXEC: begin
          exec_start_o <= 1'b0;
          if (exec_done_i) begin
            set_pc_o <= 1'b1;
            state    <= UPDATE;
            if (trap_take) begin
              pc_o      <= TRAP_VEC;
              mepc_o    <= pc_i;
              in_trap_o <= 1'b1;
            end else if (mret_i) begin
              pc_o      <= mepc_o;
              in_trap_o <= 1'b0;
            end else if (branch_taken_i) begin
              pc_o <= {branch_target_i[31:2], 2'b00};
            end else if (irq_take) begin
              pc_o      <= TRAP_VEC;
              mepc_o    <= pc_plus4;
              in_trap_o <= 1'b1;
            end else begin
              pc_o <= pc_plus4;
            end
          end
        end
        UPDATE: begin
          set_pc_o    <= 1'b0;
          fetch_req_o <= 1'b1;
          state       <= FETCH;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h00000000: boot PC.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h00000010: trap/interrupt handler entry.
REQ-003 SHALL have clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have rst_ni  input  1  synchronous, active-low reset.
REQ-005 SHALL have pc_i  input  32  current PC from the PC register.
REQ-006 SHALL have pc_o  output  32  value to load into the PC register.
REQ-007 SHALL have set_pc_o  output  1  PC register load strobe.
REQ-008 SHALL have fetch_req_o  output  1  fetch request at pc_i.
REQ-009 SHALL have fetch_ack_i  input  1  fetch complete.
REQ-010 SHALL have exec_start_o  output  1  one-cycle pulse: execute fetched instruction.
REQ-011 SHALL have exec_done_i  input  1  execute finished; qualifies the four inputs below.
REQ-012 SHALL have branch_taken_i  input  1, branch_target_i  input  32  taken branch/jump and its target.
REQ-013 SHALL have trap_i  input  1  synchronous exception (illegal instruction, ecall).
REQ-014 SHALL have mret_i  input  1  return from handler.
REQ-015 SHALL have irq_i  input  1  level-sensitive external interrupt.
REQ-016 SHALL have mepc_o  output  32, in_trap_o  output  1  saved return PC; handler active (interrupts masked).

Function
REQ-017 SHALL implement FSM states BOOT, FETCH, EXEC, UPDATE.
REQ-018 BOOT SHALL last one cycle with set_pc_o=1, pc_o=RESET_VEC, then go to FETCH.
REQ-019 FETCH SHALL hold fetch_req_o=1 until fetch_ack_i is sampled high, then go to EXEC; fetch_ack_i SHALL be ignored in all other states.
REQ-020 exec_start_o SHALL be 1 exactly in the first EXEC cycle (1 cycle after fetch_ack_i).
REQ-021 EXEC SHALL wait for exec_done_i; exec_done_i and its qualified inputs SHALL be ignored outside EXEC.
REQ-022 On exec_done_i, next PC SHALL be chosen by priority: trap_i > mret_i > branch_taken_i > irq_i (when enabled and in_trap_o=0) > pc_i+4; FSM goes to UPDATE.
REQ-023 UPDATE SHALL last one cycle with set_pc_o=1 and pc_o=the chosen PC, then go to FETCH; fetch_req_o rises the cycle after set_pc_o.
REQ-024 set_pc_o SHALL be 0 in FETCH and EXEC.
REQ-025 pc_i+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-026 branch_target_i[1:0] SHALL be forced to 2'b00 in pc_o.
REQ-027 Trap: mepc_o <= pc_i, in_trap_o <= 1, target TRAP_VEC; a trap while in_trap_o=1 SHALL overwrite mepc_o.
REQ-028 Interrupt: mepc_o <= pc_i+4, in_trap_o <= 1, target TRAP_VEC.
REQ-029 mret_i with in_trap_o=1: target mepc_o, in_trap_o <= 0; mret_i with in_trap_o=0 SHALL be handled as a trap.
REQ-030 Simultaneous trap_i and branch_taken_i SHALL take the trap; the branch is discarded.

Reset
REQ-031 rst_ni=0 at a rising edge SHALL, from any state, force state BOOT, set_pc_o=0, fetch_req_o=0, exec_start_o=0, pc_o=RESET_VEC, mepc_o=0, in_trap_o=0.
REQ-032 An outstanding fetch or execute interrupted by reset SHALL be abandoned; the first post-reset cycle is BOOT.

Configuration
REQ-033 Macro PC_SEQ_IRQ_EN defined: irq_i SHALL be honoured per REQ-022/REQ-028.
REQ-034 Macro PC_SEQ_IRQ_EN undefined: the irq_i port SHALL remain and be ignored; in_trap_o SHALL change only via trap/mret.

Verification
REQ-035 Reset release, fetch_ack_i after 2 cycles, exec_done_i with no flags -> set_pc_o pulse pc_o=0x0, exec_start_o 1 cycle after ack, then set_pc_o with pc_o=0x4.
REQ-036 pc_i=0x100, exec_done_i with branch_taken_i=1, target 0x203 -> pc_o=0x200.
REQ-037 pc_i=0x40, trap_i=1 and branch_taken_i=1 -> pc_o=0x10, mepc_o=0x40, in_trap_o=1; then mret_i -> pc_o=0x40, in_trap_o=0.
REQ-038 With PC_SEQ_IRQ_EN, irq_i=1, pc_i=0x80 -> pc_o=0x10, mepc_o=0x84; irq_i held in handler -> pc_i+4 taken; without macro -> pc_o=0x84.
REQ-039 pc_i=32'hFFFFFFFC, no flags -> pc_o=0x0; rst_ni=0 during EXEC -> BOOT next cycle, all outputs at reset values.
